// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and its direct-mapped I-cache.
package if_fetch_pkg;

  localparam int unsigned IcacheIndexW = 7;
  localparam int unsigned StallW       = 6;
  localparam int unsigned StallIfId    = 1;
  localparam int unsigned FetchBytes   = 4;

  typedef enum logic {
    StIdle,
    StFetch
  } fetch_state_e;

  function automatic logic [31:0] word_base(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, single-cycle fill.
module icache_dm
  import if_fetch_pkg::*;
#(
  parameter int unsigned INDEX_W = IcacheIndexW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_addr,
  output logic        rd_hit,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int unsigned Entries = 2 ** INDEX_W;
  localparam int unsigned TagW    = 30 - INDEX_W;

  logic [Entries-1:0] valid_q;
  logic [TagW-1:0]    tag_q  [Entries];
  logic [31:0]        data_q [Entries];

  logic [INDEX_W-1:0] rd_idx, wr_idx;
  logic [TagW-1:0]    rd_tag, wr_tag;
  logic               unused_addr_lsbs;

  assign rd_idx = rd_addr[INDEX_W+1:2];
  assign rd_tag = rd_addr[31:INDEX_W+2];
  assign wr_idx = wr_addr[INDEX_W+1:2];
  assign wr_tag = wr_addr[31:INDEX_W+2];
  assign unused_addr_lsbs = ^{rd_addr[1:0], wr_addr[1:0]};

  assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset; the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: I-cache lookup of the registered PC, byte-serial refill on a miss.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned ICACHE_INDEX_W = IcacheIndexW,
  parameter int unsigned STALL_W        = StallW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  input  logic               ex_flag,
  input  logic [STALL_W-1:0] stall_state,
  output logic               stall_req,
  output logic [31:0]        mem_a,
  output logic               mem_rd_req,
  input  logic               mem_busy,
  input  logic [7:0]         mem_din,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               inst_valid
);

  fetch_state_e state_q, state_d;
  logic [2:0]   issue_cnt_q, issue_cnt_d;
  logic [2:0]   recv_cnt_q, recv_cnt_d;
  logic         rx_pend_q, rx_pend_d;
  logic [31:0]  base_q, base_d;
  logic [31:0]  asm_q, asm_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;

  logic         hit;
  logic [31:0]  hit_data;
  logic         cache_we;
  logic [31:0]  fill_word;
  logic         hold;
  logic         unused_stall;

  assign hold         = stall_state[StallIfId];
  assign unused_stall = ^stall_state;

  icache_dm #(
    .INDEX_W(ICACHE_INDEX_W)
  ) u_icache (
    .clk    (clk),
    .rst    (rst),
    .rd_addr(pc),
    .rd_hit (hit),
    .rd_data(hit_data),
    .wr_en  (cache_we),
    .wr_addr(base_q),
    .wr_data(fill_word)
  );

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    rx_pend_d    = 1'b0;
    base_d       = base_q;
    asm_d        = asm_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    stall_req    = 1'b0;
    mem_rd_req   = 1'b0;
    mem_a        = '0;
    cache_we     = 1'b0;
    // The last byte goes straight into the cache in the cycle it arrives.
    fill_word    = {mem_din, asm_q[23:0]};

    unique case (state_q)
      StIdle: begin
        if (ex_flag) begin
          inst_valid_d = 1'b0;
        end else if (hit) begin
          if (!hold) begin
            inst_d       = hit_data;
            inst_pc_d    = pc;
            inst_valid_d = 1'b1;
          end
        end else begin
          stall_req   = 1'b1;
          state_d     = StFetch;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          base_d      = word_base(pc);
          if (!hold) begin
            inst_valid_d = 1'b0;
          end
        end
      end

      StFetch: begin
        mem_rd_req = (issue_cnt_q < 3'(FetchBytes));
        mem_a      = base_q + 32'(issue_cnt_q);
        if (ex_flag) begin
          // Dropping rx_pend discards any byte still in flight.
          state_d      = StIdle;
          issue_cnt_d  = '0;
          recv_cnt_d   = '0;
          inst_valid_d = 1'b0;
        end else begin
          stall_req = 1'b1;
          if (mem_rd_req && !mem_busy) begin
            issue_cnt_d = issue_cnt_q + 3'd1;
            rx_pend_d   = 1'b1;
          end
          if (rx_pend_q) begin
            asm_d[8*recv_cnt_q[1:0] +: 8] = mem_din;
            recv_cnt_d                    = recv_cnt_q + 3'd1;
            if (recv_cnt_q == 3'(FetchBytes - 1)) begin
              cache_we    = 1'b1;
              state_d     = StIdle;
              issue_cnt_d = '0;
              recv_cnt_d  = '0;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      rx_pend_q    <= 1'b0;
      base_q       <= '0;
      asm_q        <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      rx_pend_q    <= rx_pend_d;
      base_q       <= base_d;
      asm_q        <= asm_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: cycle checks in the stimulus, output scoreboard in a monitor.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ex_flag;
  logic [5:0]  stall_state;
  logic        stall_req;
  logic [31:0] mem_a;
  logic        mem_rd_req;
  logic        mem_busy;
  logic [7:0]  mem_din;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .ex_flag    (ex_flag),
    .stall_state(stall_state),
    .stall_req  (stall_req),
    .mem_a      (mem_a),
    .mem_rd_req (mem_rd_req),
    .mem_busy   (mem_busy),
    .mem_din    (mem_din),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h000: return 8'h13;
      32'h001: return 8'h05;
      32'h002: return 8'h00;
      32'h003: return 8'h00;
      32'h100: return 8'hb7;
      32'h101: return 8'h42;
      32'h102: return 8'h34;
      32'h103: return 8'h12;
      32'h200: return 8'h93;
      32'h201: return 8'h80;
      32'h202: return 8'hf0;
      32'h203: return 8'hff;
      default: return 8'h5a;
    endcase
  endfunction

  // Memory controller model: byte appears the cycle after acceptance, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_req && !mem_busy) mem_din <= mem_byte(mem_a);
    else mem_din <= 8'hee;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a new output is a rising inst_valid or a change of inst/inst_pc while valid.
  initial begin
    logic        prev_v;
    logic [31:0] prev_inst, prev_pc;
    exp_t        e;
    prev_v = 1'b0;
    prev_inst = '0;
    prev_pc = '0;
    forever begin
      @(negedge clk);
      if (inst_valid === 1'b1 &&
          (!prev_v || inst !== prev_inst || inst_pc !== prev_pc)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got inst %h pc %h expected none", inst, inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_inst", inst, e.inst);
          chk("sb_pc", inst_pc, e.pc);
        end
      end
      prev_v    = inst_valid;
      prev_inst = inst;
      prev_pc   = inst_pc;
    end
  end

  task automatic push_exp(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    e.inst = i;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; one cycle with ex_flag high and pc redirected, returns in the next cycle.
  task automatic flush(input logic [31:0] next_pc);
    @(negedge clk);
    ex_flag = 1'b1;
    pc      = next_pc;
    #1;
    chk("flush_stall_req", stall_req, 0);
    @(negedge clk);
    ex_flag = 1'b0;
    chk("flush_valid", inst_valid, 0);
  endtask

  task automatic wait_valid(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (inst_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, exp_cycles);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    pc = 32'h0;
    ex_flag = 1'b0;
    stall_state = '0;
    mem_busy = 1'b0;

    // Reset, then cold miss at pc 0.
    push_exp(32'h00000513, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_rd_req", mem_rd_req, 0);
    chk("rst_mem_a", mem_a, 0);
    rst = 1'b0;
    #1;
    chk("cold_c0_stall", stall_req, 1);
    chk("cold_c0_rd_req", mem_rd_req, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cold_req", mem_rd_req, 1);
      chk("cold_addr", mem_a, i);
      chk("cold_req_stall", stall_req, 1);
    end
    @(negedge clk);
    chk("cold_c5_rd_req", mem_rd_req, 0);
    chk("cold_c5_stall", stall_req, 1);
    @(negedge clk);
    chk("cold_c6_stall", stall_req, 0);
    chk("cold_c6_valid", inst_valid, 0);
    @(negedge clk);
    chk("cold_c7_valid", inst_valid, 1);
    chk("cold_c7_inst", inst, 32'h00000513);
    chk("cold_c7_pc", inst_pc, 0);

    // Hit on pc 0.
    push_exp(32'h00000513, 32'h0);
    flush(32'h0);
    #1;
    chk("hit_stall", stall_req, 0);
    chk("hit_rd_req", mem_rd_req, 0);
    @(negedge clk);
    chk("hit_valid", inst_valid, 1);
    chk("hit_inst", inst, 32'h00000513);
    chk("hit_stall2", stall_req, 0);
    chk("hit_rd_req2", mem_rd_req, 0);

    // Miss at 0x100 with mem_busy during request 1 (cycles 2-3).
    push_exp(32'h123442b7, 32'h100);
    flush(32'h100);
    #1;
    chk("busy_c0_stall", stall_req, 1);
    @(negedge clk);
    chk("busy_c1_addr", mem_a, 32'h100);
    @(negedge clk);
    mem_busy = 1'b1;
    #1;
    chk("busy_c2_addr", mem_a, 32'h101);
    @(negedge clk);
    chk("busy_c3_addr", mem_a, 32'h101);
    chk("busy_c3_rd_req", mem_rd_req, 1);
    @(negedge clk);
    mem_busy = 1'b0;
    #1;
    chk("busy_c4_addr", mem_a, 32'h101);
    wait_valid("busy_latency", 5);

    // Miss at 0x200 (same index as 0x000), flushed while recv_cnt = 2.
    flush(32'h200);
    repeat (4) @(negedge clk);
    ex_flag = 1'b1;
    #1;
    chk("fl_stall_in_flush", stall_req, 0);
    @(negedge clk);
    ex_flag = 1'b0;
    chk("fl_valid_after", inst_valid, 0);
    #1;
    chk("fl_idle_rd_req", mem_rd_req, 0);
    chk("fl_still_miss", stall_req, 1);
    push_exp(32'hfff08093, 32'h200);
    @(negedge clk);
    chk("fl_refetch_req", mem_rd_req, 1);
    chk("fl_refetch_addr", mem_a, 32'h200);
    wait_valid("fill200_latency", 6);

    // Conflict: 0x200 evicted 0x000, so 0x000 misses again.
    push_exp(32'h00000513, 32'h0);
    flush(32'h0);
    #1;
    chk("conf_stall", stall_req, 1);
    @(negedge clk);
    chk("conf_rd_req", mem_rd_req, 1);
    chk("conf_addr", mem_a, 32'h0);
    wait_valid("conf_latency", 6);

    // IF/ID hold on a hit of 0x100.
    @(negedge clk);
    stall_state = 6'b000010;
    pc = 32'h100;
    #1;
    chk("hold_stall_req", stall_req, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_inst", inst, 32'h00000513);
      chk("hold_pc", inst_pc, 32'h0);
      chk("hold_valid", inst_valid, 1);
    end
    stall_state = '0;
    push_exp(32'h123442b7, 32'h100);
    @(negedge clk);
    chk("release_inst", inst, 32'h123442b7);
    chk("release_pc", inst_pc, 32'h100);

    // Flush wins over IF/ID hold.
    @(negedge clk);
    stall_state = 6'b000010;
    flush(32'h100);
    stall_state = '0;
    push_exp(32'h123442b7, 32'h100);
    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
